// File: rtl/snow64_pipe_stage_fetch_queue_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// snow64_pipe_stage_fetch_queue_if
//
// Bundles the fetch-queue signals: the instruction-cache request/response pair,
// the queue-head handshake toward decode/EX, the EX redirect, the occupancy
// count and the fetch-state debug view.
//
// Handshake (head -> decode/EX): a transfer happens in every cycle where
// out_valid and out_ready are both high. While out_valid is high and out_ready
// is low, out_instr/out_pc hold their values. When out_valid is low,
// out_instr and out_pc are zero.
//
// Modports:
//   master : the fetch stage (drives requests, head, count, fetch_state)
//   slave  : the environment (cache, consumer, redirect source)
// -----------------------------------------------------------------------------
interface snow64_pipe_stage_fetch_queue_if #(
    parameter int WIDTH__INSTR = 32,
    parameter int WIDTH__ADDR  = 64,
    parameter int DEPTH        = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                    icache_req_valid;
    logic [WIDTH__ADDR-1:0]  icache_req_addr;
    logic                    icache_resp_valid;
    logic [WIDTH__INSTR-1:0] icache_resp_instr;
    logic                    out_valid;
    logic [WIDTH__INSTR-1:0] out_instr;
    logic [WIDTH__ADDR-1:0]  out_pc;
    logic                    out_ready;
    logic                    redirect_valid;
    logic [WIDTH__ADDR-1:0]  redirect_pc;
    logic [CNT_W-1:0]        queue_count;
    logic                    fetch_state;   // 0 = fetching, 1 = halted on control flow

    modport master (
        output icache_req_valid, icache_req_addr,
        input  icache_resp_valid, icache_resp_instr,
        output out_valid, out_instr, out_pc,
        input  out_ready,
        input  redirect_valid, redirect_pc,
        output queue_count, fetch_state
    );

    modport slave (
        input  icache_req_valid, icache_req_addr,
        output icache_resp_valid, icache_resp_instr,
        input  out_valid, out_instr, out_pc,
        output out_ready,
        output redirect_valid, redirect_pc,
        input  queue_count, fetch_state
    );
endinterface

// File: rtl/snow64_pipe_stage_fetch_queue.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// snow64_pipe_stage_fetch_queue
//
// Fetch front end: requests instructions from the instruction cache, stores
// hits as {pc, instr} pairs in a DEPTH-entry circular queue and presents the
// queue head to decode/EX. Fetch stops after enqueuing an instruction whose
// group field equals CTRL_FLOW_GROUP and restarts on an EX redirect, which
// also flushes the queue.
//
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : synchronous, active-high reset
//   bus  : snow64_pipe_stage_fetch_queue_if.master
//            icache_req_valid/addr    -> fetch request for fetch_pc
//            icache_resp_valid/instr  <- same-cycle hit and its instruction
//            out_valid/instr/pc       -> queue head (valid/ready handshake)
//            out_ready                <- consumer accepts head
//            redirect_valid/pc        <- EX PC change, highest priority
//            queue_count              -> occupancy
//            fetch_state              -> FSM state (0 fetching, 1 halted)
//
// Configuration macro: SNOW64_FETCH_QUEUE_BYPASS_EN
//   Defined   : a hit arriving while the queue is empty and out_ready is high
//               goes straight to the outputs in the same cycle, not enqueued.
//   Undefined : every instruction passes through the queue (1-cycle latency,
//               no combinational cache-to-output path).
// -----------------------------------------------------------------------------
module snow64_pipe_stage_fetch_queue #(
    parameter int                      WIDTH__INSTR    = 32,
    parameter int                      WIDTH__ADDR     = 64,
    parameter int                      DEPTH           = 4,
    parameter int                      GROUP_LSB       = 28,
    parameter int                      CTRL_FLOW_GROUP = 1,
    parameter logic [WIDTH__ADDR-1:0]  RESET_PC        = '0
) (
    input  logic clk,
    input  logic rst,
    snow64_pipe_stage_fetch_queue_if.master bus
);
    localparam int INSTR_BYTES = WIDTH__INSTR / 8;
    localparam int PTR_W       = $clog2(DEPTH);
    localparam int CNT_W       = PTR_W + 1;

    localparam logic [WIDTH__ADDR-1:0] ADDR_STEP = WIDTH__ADDR'(INSTR_BYTES);
    // Clears the byte-offset bits inside one instruction.
    localparam logic [WIDTH__ADDR-1:0] ADDR_MASK = ~(ADDR_STEP - WIDTH__ADDR'(1));

    typedef enum logic [0:0] {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [WIDTH__ADDR-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [WIDTH__ADDR-1:0]  pc_mem_q    [DEPTH];
    logic [WIDTH__INSTR-1:0] instr_mem_q [DEPTH];

    logic req_valid;
    logic hit;
    logic resp_is_ctrl;
    logic head_valid;
    logic push;
    logic pop;

    // A full queue blocks the request even if the head pops this cycle.
    assign req_valid    = !rst && (state_q == ST_FETCH) && !bus.redirect_valid
                          && (count_q < CNT_W'(DEPTH));
    assign hit          = req_valid && bus.icache_resp_valid;
    assign resp_is_ctrl = (bus.icache_resp_instr[GROUP_LSB +: 2] == 2'(CTRL_FLOW_GROUP));
    // A redirect hides the head so nothing is consumed in the flush cycle.
    assign head_valid   = !rst && !bus.redirect_valid && (count_q != '0);

    assign bus.icache_req_valid = req_valid;
    assign bus.icache_req_addr  = fetch_pc_q;
    assign bus.queue_count      = count_q;
    assign bus.fetch_state      = state_q;

    // Output selection and push/pop decisions.
    always_comb begin
        bus.out_valid = head_valid;
        bus.out_instr = head_valid ? instr_mem_q[rd_ptr_q] : '0;
        bus.out_pc    = head_valid ? pc_mem_q[rd_ptr_q]    : '0;
        push          = hit;
        pop           = head_valid && bus.out_ready;
`ifdef SNOW64_FETCH_QUEUE_BYPASS_EN
        // Empty queue means head_valid is low, so pop is already 0 here.
        if (hit && (count_q == '0) && bus.out_ready) begin
            bus.out_valid = 1'b1;
            bus.out_instr = bus.icache_resp_instr;
            bus.out_pc    = fetch_pc_q;
            push          = 1'b0;
        end
`endif
    end

    // Next-state logic: FSM, fetch PC, pointers and occupancy.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (bus.redirect_valid) begin
            state_d    = ST_FETCH;
            fetch_pc_d = bus.redirect_pc & ADDR_MASK;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (hit) begin
                fetch_pc_d = fetch_pc_q + ADDR_STEP;
                if (resp_is_ctrl) begin
                    state_d = ST_HALTED;
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= bus.icache_resp_instr;
        end
    end

endmodule

// File: tb/tb_snow64_pipe_stage_fetch_queue.sv
`timescale 1ns/1ps
module tb_snow64_pipe_stage_fetch_queue;
    localparam int WI = 32;
    localparam int WA = 64;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic rst;
    logic miss;
    logic [WA-1:0] ctrl_pc;
    int n_checks = 0;
    int n_errors = 0;

    snow64_pipe_stage_fetch_queue_if #(.WIDTH__INSTR(WI), .WIDTH__ADDR(WA), .DEPTH(DP)) bus ();

    snow64_pipe_stage_fetch_queue #(
        .WIDTH__INSTR(WI), .WIDTH__ADDR(WA), .DEPTH(DP),
        .GROUP_LSB(28), .CTRL_FLOW_GROUP(1), .RESET_PC('0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---- clock ----
    always #5 clk = ~clk;

    // ---- instruction cache model: instr = {2'b00, group, addr[27:0]} ----
    function automatic logic [WI-1:0] make_instr(input logic [WA-1:0] addr, input logic [WA-1:0] cpc);
        logic [1:0] grp;
        grp = (addr == cpc) ? 2'b01 : 2'b00;
        return {2'b00, grp, addr[27:0]};
    endfunction

    always_comb begin
        bus.icache_resp_valid = !miss;
        bus.icache_resp_instr = make_instr(bus.icache_req_addr, ctrl_pc);
    end

    // ---- check helper ----
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // ---- directed stimulus ----
    initial begin
        rst = 1'b1;
        miss = 1'b0;
        ctrl_pc = '1;
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", bus.icache_req_valid, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_instr", bus.out_instr, 0);
        chk("rst_out_pc", bus.out_pc, 0);
        chk("rst_count", bus.queue_count, 0);

        // First request right after reset release
        rst = 1'b0;
        #1;
        chk("first_req_valid", bus.icache_req_valid, 1);
        chk("first_req_addr", bus.icache_req_addr, 0);
        chk("first_out_valid", bus.out_valid, 0);

        // Streaming: one instruction per cycle, 1-cycle latency, count stays 1
        for (int k = 1; k <= 5; k++) begin
            adv();
            chk("stream_out_valid", bus.out_valid, 1);
            chk("stream_out_pc", bus.out_pc, 64'(4 * (k - 1)));
            chk("stream_out_instr", bus.out_instr, 64'(make_instr(64'(4 * (k - 1)), ctrl_pc)));
            chk("stream_req_addr", bus.icache_req_addr, 64'(4 * k));
            chk("stream_count", bus.queue_count, 1);
        end

        // Redirect to 0 and stall the consumer
        adv();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'h0;
        bus.out_ready = 1'b0;
        #1;
        chk("redir_out_valid", bus.out_valid, 0);
        chk("redir_out_instr", bus.out_instr, 0);
        chk("redir_req_valid", bus.icache_req_valid, 0);
        adv();
        bus.redirect_valid = 1'b0;
        #1;
        chk("stall_count0", bus.queue_count, 0);
        chk("stall_addr0", bus.icache_req_addr, 0);
        chk("stall_req0", bus.icache_req_valid, 1);
        for (int k = 1; k <= 3; k++) begin
            adv();
            chk("stall_fill_count", bus.queue_count, 64'(k));
            chk("stall_fill_addr", bus.icache_req_addr, 64'(4 * k));
            chk("stall_head_pc", bus.out_pc, 0);
        end
        adv();
        chk("full_count", bus.queue_count, 4);
        chk("full_req_valid", bus.icache_req_valid, 0);
        chk("full_addr", bus.icache_req_addr, 64'h10);
        adv();
        chk("full_hold_pc", bus.out_pc, 0);
        chk("full_hold_instr", bus.out_instr, 64'(make_instr(64'h0, ctrl_pc)));
        chk("full_hold_count", bus.queue_count, 4);
        bus.out_ready = 1'b1;
        #1;
        chk("full_pop_no_req", bus.icache_req_valid, 0);
        adv();
        chk("drain1_count", bus.queue_count, 3);
        chk("drain1_pc", bus.out_pc, 64'h4);
        chk("drain1_req", bus.icache_req_valid, 1);
        chk("drain1_addr", bus.icache_req_addr, 64'h10);
        adv();
        chk("drain2_pc", bus.out_pc, 64'h8);
        chk("drain2_addr", bus.icache_req_addr, 64'h14);
        adv();
        chk("drain3_pc", bus.out_pc, 64'hC);
        chk("drain3_count", bus.queue_count, 3);

        // Redirect with 3 entries and out_ready high: no pop, flushed
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'h2;
        #1;
        chk("flush_no_pop", bus.out_valid, 0);
        chk("flush_no_req", bus.icache_req_valid, 0);
        adv();
        bus.redirect_valid = 1'b0;
        #1;
        chk("flush_count", bus.queue_count, 0);
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_addr_masked", bus.icache_req_addr, 64'h0);

        // Miss at 0x8 for three cycles
        adv();
        chk("miss_pre_pc", bus.out_pc, 64'h0);
        chk("miss_pre_addr", bus.icache_req_addr, 64'h4);
        adv();
        miss = 1'b1;
        #1;
        chk("miss1_pc", bus.out_pc, 64'h4);
        chk("miss1_addr", bus.icache_req_addr, 64'h8);
        adv();
        chk("miss2_count", bus.queue_count, 0);
        chk("miss2_out_valid", bus.out_valid, 0);
        chk("miss2_out_instr", bus.out_instr, 0);
        chk("miss2_addr", bus.icache_req_addr, 64'h8);
        adv();
        chk("miss3_addr", bus.icache_req_addr, 64'h8);
        chk("miss3_req", bus.icache_req_valid, 1);
        adv();
        miss = 1'b0;
        #1;
        chk("miss_hit_addr", bus.icache_req_addr, 64'h8);
        chk("miss_hit_count", bus.queue_count, 0);
        adv();
        miss = 1'b1;
        #1;
        chk("miss_enq_count", bus.queue_count, 1);
        chk("miss_enq_pc", bus.out_pc, 64'h8);
        chk("miss_enq_addr", bus.icache_req_addr, 64'hC);
        adv();
        chk("miss_once_count", bus.queue_count, 0);
        chk("miss_once_valid", bus.out_valid, 0);

        // Control-flow instruction at 0x4 halts fetch
        miss = 1'b0;
        ctrl_pc = 64'h4;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'h0;
        adv();
        bus.redirect_valid = 1'b0;
        #1;
        chk("cf_addr0", bus.icache_req_addr, 64'h0);
        adv();
        chk("cf_pc0", bus.out_pc, 64'h0);
        chk("cf_addr4", bus.icache_req_addr, 64'h4);
        adv();
        chk("cf_halt_req", bus.icache_req_valid, 0);
        chk("cf_head_pc", bus.out_pc, 64'h4);
        chk("cf_head_instr", bus.out_instr, 64'h1000_0004);
        chk("cf_state", bus.fetch_state, 1);
        adv();
        chk("cf_halt_req2", bus.icache_req_valid, 0);
        chk("cf_empty", bus.out_valid, 0);
        adv();
        chk("cf_halt_req3", bus.icache_req_valid, 0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'h103;
        ctrl_pc = '1;
        adv();
        bus.redirect_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("cf_resume_req", bus.icache_req_valid, 1);
        chk("cf_resume_addr", bus.icache_req_addr, 64'h100);
        chk("cf_resume_state", bus.fetch_state, 0);

        // Fill the queue, then reset mid-stream
        repeat (4) adv();
        chk("rfull_count", bus.queue_count, 4);
        chk("rfull_addr", bus.icache_req_addr, 64'h110);
        rst = 1'b1;
        #1;
        chk("rmid_req", bus.icache_req_valid, 0);
        adv();
        rst = 1'b0;
        #1;
        chk("rmid_count", bus.queue_count, 0);
        chk("rmid_out_valid", bus.out_valid, 0);
        chk("rmid_addr", bus.icache_req_addr, 64'h0);
        chk("rmid_req_after", bus.icache_req_valid, 1);
        adv();
        chk("rmid_refill_count", bus.queue_count, 1);
        chk("rmid_refill_pc", bus.out_pc, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
